// File: rtl/cache_pkg.sv
// Shared types and address helpers for the set-associative data cache.
// Provides the FSM state enum, field-width functions and field extract/pack.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RF
  } state_e;

  function automatic int off_w(input int bw);
    return $clog2(bw);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int bw);
    return 30 - $clog2(bw) - $clog2(sets);
  endfunction

  function automatic logic [31:0] f_off(input logic [31:0] a,
                                        input int bw);
    return (a >> 2) & 32'(bw - 1);
  endfunction

  function automatic logic [31:0] f_idx(input logic [31:0] a,
                                        input int sets,
                                        input int bw);
    return (a >> (2 + off_w(bw))) & 32'(sets - 1);
  endfunction

  function automatic logic [31:0] f_tag(input logic [31:0] a,
                                        input int sets,
                                        input int bw);
    return a >> (2 + off_w(bw) + idx_w(sets));
  endfunction

  function automatic logic [31:0] f_pack(input logic [31:0] tag,
                                         input logic [31:0] idx,
                                         input logic [31:0] off,
                                         input int sets,
                                         input int bw);
    return (tag << (2 + off_w(bw) + idx_w(sets)))
         | (idx << (2 + off_w(bw)))
         | (off << 2);
  endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: valid/dirty bits, tag array and data array for all sets.
// Ports: shared index, combinational read/match, one-word write, fill/dirty control.
module cache_way import cache_pkg::*; #(
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int IDXW        = 2,
  parameter int OFFW        = 2,
  parameter int TAGW        = 26
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IDXW-1:0] idx_i,
  input  logic [OFFW-1:0] rd_off_i,
  input  logic [TAGW-1:0] cmp_tag_i,
  output logic            match_o,
  output logic            valid_o,
  output logic            dirty_o,
  output logic [TAGW-1:0] tag_o,
  output logic [31:0]     rdata_o,
  input  logic            we_i,
  input  logic [OFFW-1:0] wr_off_i,
  input  logic [31:0]     wr_data_i,
  input  logic            set_dirty_i,
  input  logic            clr_dirty_i,
  input  logic            fill_i,
  input  logic [TAGW-1:0] fill_tag_i
);

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [31:0]     data_q [SETS][BLOCK_WORDS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_i) begin
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end
      if (set_dirty_i) dirty_q[idx_i] <= 1'b1;
      if (clr_dirty_i) dirty_q[idx_i] <= 1'b0;
    end
  end

  // Tag and data storage are never cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) data_q[idx_i][wr_off_i] <= wr_data_i;
    if (fill_i) tag_q[idx_i] <= fill_tag_i;
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign rdata_o = data_q[idx_i][rd_off_i];
  assign match_o = valid_o && (tag_o == cmp_tag_i);

endmodule

// File: rtl/cache_sa.sv
// N-way set-associative write-back, write-allocate data cache.
// Ports: pipeline side (Addr/WE/WD/Hit/RD/Suspense), word-wide memory port (MReq..MRD).
module cache_sa import cache_pkg::*; #(
  parameter int SETS        = 4,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Suspense,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WD,
  output logic        Hit,
  output logic [31:0] RD,
  output logic        MReq,
  output logic [31:0] MAddr,
  output logic        MWE,
  output logic [31:0] MWD,
  input  logic        MReady,
  input  logic [31:0] MRD
);

  localparam int OFF  = off_w(BLOCK_WORDS);
  localparam int OFFW = (OFF > 0) ? OFF : 1;
  localparam int IDX  = idx_w(SETS);
  localparam int TAG  = tag_w(SETS, BLOCK_WORDS);
  localparam int PW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e          state_q;
  logic [OFFW-1:0] w_q;
  logic [IDX-1:0]  idx_q;
  logic [TAG-1:0]  rtag_q;
  logic [PW-1:0]   vic_q;
  logic [PW-1:0]   ptr_q [SETS];

  logic [OFFW-1:0] r_off;
  logic [IDX-1:0]  r_idx;
  logic [TAG-1:0]  r_tag;
  logic [IDX-1:0]  cur_idx;
  logic [OFFW-1:0] rd_off;

  logic [WAYS-1:0] match, vld, drt;
  logic [TAG-1:0]  wtag [WAYS];
  logic [31:0]     wdat [WAYS];

  logic            any_hit, inv_found, miss_go, last;
  logic [PW-1:0]   hit_way, inv_way, vic;

  logic            wr_en, set_dirty, clr_dirty, fill;
  logic [PW-1:0]   wr_way;
  logic [OFFW-1:0] wr_off;
  logic [31:0]     wr_data;
  logic [TAG-1:0]  out_tag;

  assign r_off = OFFW'(f_off(Addr, BLOCK_WORDS));
  assign r_idx = IDX'(f_idx(Addr, SETS, BLOCK_WORDS));
  assign r_tag = TAG'(f_tag(Addr, SETS, BLOCK_WORDS));

  // While a transfer runs, the latched index addresses the arrays.
  assign cur_idx = (state_q == S_IDLE) ? r_idx : idx_q;
  assign rd_off  = (state_q == S_WB) ? w_q : r_off;
  assign last    = (w_q == OFFW'(BLOCK_WORDS - 1));

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(
      .SETS(SETS), .BLOCK_WORDS(BLOCK_WORDS),
      .IDXW(IDX), .OFFW(OFFW), .TAGW(TAG)
    ) u_way (
      .clk_i      (CLK),
      .rst_i      (Reset),
      .idx_i      (cur_idx),
      .rd_off_i   (rd_off),
      .cmp_tag_i  (r_tag),
      .match_o    (match[g]),
      .valid_o    (vld[g]),
      .dirty_o    (drt[g]),
      .tag_o      (wtag[g]),
      .rdata_o    (wdat[g]),
      .we_i       (wr_en && (wr_way == PW'(g))),
      .wr_off_i   (wr_off),
      .wr_data_i  (wr_data),
      .set_dirty_i(set_dirty && (wr_way == PW'(g))),
      .clr_dirty_i(clr_dirty && (wr_way == PW'(g))),
      .fill_i     (fill && (wr_way == PW'(g))),
      .fill_tag_i (rtag_q)
    );
  end

  // Lowest-index invalid way beats the round-robin pointer.
  always_comb begin
    any_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (match[i]) begin
        any_hit = 1'b1;
        hit_way = PW'(i);
      end
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!vld[i]) begin
        inv_found = 1'b1;
        inv_way   = PW'(i);
      end
    end
  end

  assign vic = inv_found ? inv_way
             : ((WAYS > 1) ? ptr_q[r_idx] : '0);

  assign Hit = (state_q == S_IDLE) && !Suspense && !Reset && any_hit;
  assign RD  = Hit ? wdat[hit_way] : '0;
  assign miss_go = (state_q == S_IDLE) && !Suspense && !Reset && !any_hit;

  always_comb begin
    wr_en     = 1'b0;
    set_dirty = 1'b0;
    clr_dirty = 1'b0;
    fill      = 1'b0;
    wr_way    = hit_way;
    wr_off    = r_off;
    wr_data   = WD;
    unique case (state_q)
      S_IDLE: begin
        if (Hit && WE) begin
          wr_en     = 1'b1;
          set_dirty = 1'b1;
        end
      end
      S_WB: begin
        wr_way = vic_q;
        if (MReady && last) clr_dirty = 1'b1;
      end
      S_RF: begin
        wr_way  = vic_q;
        wr_off  = w_q;
        wr_data = MRD;
        if (MReady) begin
          wr_en = 1'b1;
          fill  = last;
        end
      end
      default: ;
    endcase
  end

  assign out_tag = (state_q == S_WB) ? wtag[vic_q] : rtag_q;
  assign MReq    = (state_q != S_IDLE);
  assign MWE     = (state_q == S_WB);
  assign MWD     = MWE ? wdat[vic_q] : '0;
  assign MAddr   = MReq ? f_pack(32'(out_tag), 32'(idx_q), 32'(w_q),
                                 SETS, BLOCK_WORDS)
                        : '0;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (miss_go) begin
            idx_q  <= r_idx;
            rtag_q <= r_tag;
            vic_q  <= vic;
            w_q    <= '0;
            if ((WAYS > 1) && !inv_found)
              ptr_q[r_idx] <= ptr_q[r_idx] + 1'b1;
            state_q <= (vld[vic] && drt[vic]) ? S_WB : S_RF;
          end
        end
        S_WB: begin
          if (MReady) begin
            w_q <= last ? '0 : w_q + 1'b1;
            if (last) state_q <= S_RF;
          end
        end
        S_RF: begin
          if (MReady) begin
            w_q <= last ? '0 : w_q + 1'b1;
            if (last) state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_sa.sv
// Scoreboard bench for cache_sa: model predicts bus transactions and load data.
// A memory responder and a hit monitor pop and compare independently.
module tb_cache_sa;

  logic        CLK = 1'b0;
  logic        Reset, Suspense, WE;
  logic [31:0] Addr, WD;
  logic        Hit, MReq, MWE;
  logic [31:0] RD, MAddr, MWD;
  logic        MReady = 1'b0;
  logic [31:0] MRD = 32'h0;

  cache_sa dut (
    .CLK(CLK), .Reset(Reset), .Suspense(Suspense),
    .Addr(Addr), .WE(WE), .WD(WD),
    .Hit(Hit), .RD(RD),
    .MReq(MReq), .MAddr(MAddr), .MWE(MWE), .MWD(MWD),
    .MReady(MReady), .MRD(MRD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;

  typedef struct {
    bit          we;
    logic [31:0] data;
  } rsp_t;

  tx_t  txq[$];
  rsp_t rq[$];
  logic [31:0] mem  [int];
  logic [31:0] gold [int];

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int cnt   = 0;
  int acc   = 0;

  logic [31:0] h_addr, h_wd;
  logic        h_we;

  bit mv [4][2];
  bit md [4][2];
  int mt [4][2];
  int mp [4];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int k = int'(a >> 2);
    return mem.exists(k) ? mem[k] : {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] grd(input logic [31:0] a);
    int k = int'(a >> 2);
    return gold.exists(k) ? gold[k] : {a[31:2], 2'b00};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      mp[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 0;
        md[s][w] = 0;
      end
    end
  endtask

  task automatic predict(input logic [31:0] a, input bit we,
                         input logic [31:0] d);
    logic [31:0] wa;
    int idx, tag, hw, v;
    tx_t t;
    rsp_t r;
    wa  = {a[31:2], 2'b00};
    idx = int'((wa >> 4) & 32'd3);
    tag = int'(wa >> 6);
    hw  = -1;
    for (int w = 0; w < 2; w++)
      if (mv[idx][w] && mt[idx][w] == tag) hw = w;
    if (hw < 0) begin
      v = -1;
      for (int w = 0; w < 2; w++)
        if (!mv[idx][w] && v < 0) v = w;
      if (v < 0) begin
        v = mp[idx];
        mp[idx] = (mp[idx] + 1) % 2;
      end
      if (mv[idx][v] && md[idx][v]) begin
        for (int k = 0; k < 4; k++) begin
          t.we   = 1;
          t.addr = 32'((mt[idx][v] << 6) | (idx << 4) | (k << 2));
          t.data = grd(t.addr);
          txq.push_back(t);
        end
      end
      for (int k = 0; k < 4; k++) begin
        t.we   = 0;
        t.addr = 32'((tag << 6) | (idx << 4) | (k << 2));
        t.data = 32'h0;
        txq.push_back(t);
      end
      mv[idx][v] = 1;
      md[idx][v] = 0;
      mt[idx][v] = tag;
      hw = v;
    end
    if (we) begin
      md[idx][hw] = 1;
      gold[int'(wa >> 2)] = d;
    end
    r.we   = we;
    r.data = grd(wa);
    rq.push_back(r);
  endtask

  // Memory responder: waits lat cycles per word, then accepts it.
  always @(negedge CLK) begin : responder
    tx_t t;
    if (MReady || Reset) cnt = 0;
    MReady = 1'b0;
    if (!MReq) begin
      check("idle_bus", MAddr | MWD | {31'b0, MWE}, 32'h0);
    end else if (!Reset) begin
      if (cnt == 0) begin
        h_addr = MAddr;
        h_we   = MWE;
        h_wd   = MWD;
      end else begin
        check("hold_addr", MAddr, h_addr);
        check("hold_we", {31'b0, MWE}, {31'b0, h_we});
        check("hold_wd", MWD, h_wd);
      end
      if (cnt >= lat) begin
        MReady = 1'b1;
        acc++;
        MRD = MWE ? 32'h0 : mrd(MAddr);
        total++;
        if (txq.size() == 0) begin
          bad++;
          $display("FAIL spurious_tx got=%h want=none", MAddr);
        end else begin
          total--;
          t = txq.pop_front();
          check("tx_we", {31'b0, MWE}, {31'b0, t.we});
          check("tx_addr", MAddr, t.addr);
          if (t.we) check("tx_wd", MWD, t.data);
        end
        if (MWE) mem[int'(MAddr >> 2)] = MWD;
      end else begin
        cnt++;
      end
    end
  end

  // Hit monitor: every completed access consumes one expected response.
  always @(negedge CLK) begin : hit_mon
    rsp_t r;
    if (Hit && !Reset) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_hit got=%h want=none", Addr);
      end else begin
        r = rq.pop_front();
        if (!r.we) check("load_rd", RD, r.data);
      end
    end
  end

  task automatic wait_hit(output int mc);
    bit done = 0;
    mc = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge CLK);
      if (Hit) done = 1;
      else if (MReq) mc++;
    end
    check("hit_seen", {31'b0, done}, 32'h1);
  endtask

  task automatic access(input logic [31:0] a, input bit we,
                        input logic [31:0] d, output int mc);
    predict(a, we, d);
    Addr = a;
    WE = we;
    WD = d;
    Suspense = 1'b0;
    wait_hit(mc);
    @(posedge CLK);
    #1;
    Suspense = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int mc, a0;
    logic [31:0] a;
    Reset = 1'b1;
    Suspense = 1'b1;
    Addr = 32'h0;
    WE = 1'b0;
    WD = 32'h0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_hit", {31'b0, Hit}, 32'h0);
    check("rst_rd", RD, 32'h0);
    check("rst_mreq", {31'b0, MReq}, 32'h0);
    check("rst_maddr", MAddr, 32'h0);
    check("rst_mwe", {31'b0, MWE}, 32'h0);
    check("rst_mwd", MWD, 32'h0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    lat = 0;
    access(32'h4, 0, 32'h0, mc);
    check("cold_miss_words", mc, 4);
    access(32'h4, 1, 32'hE, mc);
    check("store_hit_wait", mc, 0);
    access(32'h4, 0, 32'h0, mc);
    check("load_hit_wait", mc, 0);
    access(32'h40, 0, 32'h0, mc);
    check("fill_way1_words", mc, 4);
    access(32'h80, 0, 32'h0, mc);
    check("dirty_evict_words", mc, 8);

    lat = 3;
    predict(32'hC0, 0, 32'h0);
    Addr = 32'hC0;
    WE = 1'b0;
    Suspense = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("susp_mreq", {31'b0, MReq}, 32'h0);
      check("susp_hit", {31'b0, Hit}, 32'h0);
    end
    @(posedge CLK);
    #1;
    Suspense = 1'b0;
    @(negedge CLK);
    check("susp_release_mreq", {31'b0, MReq}, 32'h0);
    wait_hit(mc);
    check("slow_refill_cycles", mc, 16);
    @(posedge CLK);
    #1;
    Suspense = 1'b1;

    lat = 0;
    predict(32'h100, 0, 32'h0);
    Addr = 32'h100;
    WE = 1'b0;
    Suspense = 1'b0;
    a0 = acc;
    for (int i = 0; i < 50 && acc < a0 + 2; i++) begin
      @(posedge CLK);
      #1;
    end
    check("rst_mid_words", acc - a0, 2);
    Reset = 1'b1;
    txq.delete();
    rq.delete();
    model_reset();
    gold = mem;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    predict(32'h100, 0, 32'h0);
    @(negedge CLK);
    check("post_rst_mreq", {31'b0, MReq}, 32'h0);
    check("post_rst_hit", {31'b0, Hit}, 32'h0);
    wait_hit(mc);
    check("post_rst_refill", mc, 4);
    @(posedge CLK);
    #1;
    Suspense = 1'b1;

    for (int n = 0; n < 250; n++) begin
      a = 32'($urandom_range(0, 127)) << 2;
      a = a | 32'($urandom_range(0, 3));
      lat = $urandom_range(0, 2);
      access(a, 1'($urandom_range(0, 1)), $urandom, mc);
    end

    repeat (3) @(negedge CLK);
    check("txq_empty", txq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_sa.md
Name: cache_sa

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache.
- Successor to the direct-mapped pipeline data cache. Sits between the MEM stage of the MIPS pipeline and dmem.
- Pipeline stalls while Hit=0. The cache performs whole-block writeback and refill over a one-word-per-handshake memory port.

Parameters:
- SETS, 4, number of sets (power of 2, >=2).
- WAYS, 2, associativity (power of 2, 1..8).
- BLOCK_WORDS, 4, 32-bit words per line (power of 2, >=1).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Suspense  in  1  pipeline freeze: no write, no new miss started, Hit forced 0.
- Addr  in  32  byte address; [1:0] ignored. Fields from low to high: word offset, index, tag.
- WE  in  1  1 = store, 0 = load.
- WD  in  32  store data.
- Hit  out  1  request complete this cycle (combinational).
- RD  out  32  load data, valid when Hit=1, else 0.
- MReq  out  1  memory transaction request.
- MAddr  out  32  word-aligned memory address.
- MWE  out  1  1 = writeback word, 0 = refill read.
- MWD  out  32  writeback data.
- MReady  in  1  memory completed current word (sampled at posedge while MReq=1).
- MRD  in  32  refill data, valid when MReady=1.

Behaviour:
- Field widths:
  - OFF = log2(BLOCK_WORDS).
  - IDX = log2(SETS).
  - TAG = 30-OFF-IDX.
- Per line state: valid, dirty, tag, BLOCK_WORDS data words.
- Per set state: round-robin victim pointer, log2(WAYS) bits. A WAYS=1 build has no pointer.
- FSM has three states: IDLE, WRITEBACK, REFILL.
- IDLE:
  - Hit=1 iff Suspense=0 and some valid way in the indexed set has a matching tag.
  - Load hit: RD = selected word, combinational, zero-cycle latency.
  - Store hit: word written at posedge and the line's dirty bit set. Hit is asserted in the same cycle.
  - Miss with Suspense=0: victim = way pointed to by the set pointer; that pointer then increments modulo WAYS.
    - Invalid ways are preferred over the pointer, lowest index first. In that case the pointer is unchanged.
    - Victim valid and dirty -> WRITEBACK; otherwise -> REFILL.
  - Suspense=1: no transition, no array write, Hit=0.
- WRITEBACK:
  - Word counter w runs from 0 to BLOCK_WORDS-1.
  - Drives MReq=1, MWE=1, MAddr={victim tag, index, w, 2'b00}, MWD=victim word w.
  - On a posedge with MReady=1: w increments. On the last word, the victim dirty bit clears and the FSM goes to REFILL.
- REFILL:
  - Drives MReq=1, MWE=0, MAddr={request tag, index, w, 2'b00}.
  - On a posedge with MReady=1: MRD is written to word w. After the last word, the line is marked valid, clean, with tag = request tag, and the FSM goes to IDLE.
  - The retried access then hits in the next cycle. A store retry sets dirty.
- Handshake:
  - MAddr/MWE/MWD are held stable until MReady is sampled 1. MReq may stay high across consecutive words.
  - MReady is ignored when MReq=0.
  - Memory latency is arbitrary (>=1 cycle).
- Miss latency:
  - Clean victim: BLOCK_WORDS handshakes, then Hit in the next IDLE cycle.
  - Dirty victim: 2*BLOCK_WORDS handshakes.
- Suspense is ignored in WRITEBACK/REFILL; a block transfer always completes.
- The pipeline holds Addr/WE/WD stable while Hit=0. The cache latches the index and request tag at miss start and uses the latched values.
- Reset, including mid-transfer, on the next posedge:
  - FSM to IDLE, w=0.
  - All valid/dirty bits cleared, all pointers cleared.
  - A partially refilled line stays invalid.
  - Data/tag arrays are not cleared.
- Reset values of outputs: Hit=0, RD=0, MReq=0, MWE=0, MAddr=0, MWD=0.
- Outputs when MReq=0: MAddr, MWE and MWD drive 0.

Decomposition:
- cache_pkg:
  - FSM state enum (IDLE, WRITEBACK, REFILL).
  - Functions for OFF/IDX/TAG widths and for address field extraction and packing.
- Sub-module cache_way, instantiated WAYS times: one way's valid, dirty, tag and data arrays.
  - Read port: combinational by index and word.
  - Write port: one word per cycle, plus set/clear of valid and dirty.
  - Tag-match output.
- Top level holds the FSM, victim pointers, hit mux and memory port.

Test Plan (SETS=4, WAYS=2, BLOCK_WORDS=4; dmem preloaded mem[a]=a):
- Reset, then load 0x0000_0004 -> Hit=0; MReq with MAddr 0x0, 0x4, 0x8, 0xC, MWE=0; then Hit=1, RD=0x4.
- Store 0x0000_0004 WD=0x0000_000E on the resident line -> Hit=1 the same cycle, MReq stays 0; following load of 0x4 gives RD=0xE.
- Load 0x40, then load 0x80 (both index 0) -> 0x40 fills way 1 with no writeback. 0x80 evicts way 0, which is dirty: writeback MWE=1 MAddr 0x0..0xC with MWD 0x0, 0xE, 0x8, 0xC. Then refill 0x80..0x8C; RD=0x80.
- Miss on 0xC0 while Suspense=1 for 3 cycles -> MReq=0, Hit=0. Suspense falls -> refill starts the next cycle.
- MReady delayed 3 cycles per word -> MAddr/MWE/MWD constant until the accepting posedge. Total refill takes 16 cycles.
- Reset asserted after 2 refill words -> next cycle MReq=0, Hit=0. A re-access of the same address misses and refills from word 0.
